// File: rtl/depkt_pkg.sv
// Shared constants for the depacketizer: FSM encodings, sync header table and type bytes.
package depkt_pkg;

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_TYPE   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CTRL   = 3'd4;
    localparam logic [2:0] ST_DROP   = 3'd5;

    localparam int unsigned SYNC_LEN = 12;

    localparam logic [7:0] TYPE_DATA = 8'hFF;
    localparam logic [7:0] TYPE_CTRL = 8'h00;

    // Longest control payload accepted before the packet is dropped.
    localparam logic [6:0] CTRL_MAX = 7'h7F;

    function automatic logic [7:0] sync_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    sync_byte = 8'h0A;
            4'd1:    sync_byte = 8'h01;
            4'd2:    sync_byte = 8'h02;
            4'd3:    sync_byte = 8'h03;
            4'd4:    sync_byte = 8'h04;
            4'd5:    sync_byte = 8'h05;
            4'd6:    sync_byte = 8'h0A;
            4'd7:    sync_byte = 8'h01;
            4'd8:    sync_byte = 8'h02;
            4'd9:    sync_byte = 8'h03;
            4'd10:   sync_byte = 8'h04;
            4'd11:   sync_byte = 8'hCC;
            default: sync_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/depkt_sync_match.sv
// Sync header tracker: walks the 12-byte header table and flags completion or mismatch.
module depkt_sync_match
    import depkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       check,
    input  logic [8:0] in_data,
    output logic       match_done,
    output logic       mismatch,
    output logic       restart
);

    logic [3:0] idx_q, idx_d;
    logic       match;

    assign match      = (in_data == {1'b1, sync_byte(idx_q)});
    assign match_done = check && match && (idx_q == 4'(SYNC_LEN - 1));
    assign mismatch   = check && !match;
    // A stray 0A mid-header may itself be the start of a fresh header.
    assign restart    = mismatch && (in_data == {1'b1, sync_byte(4'd0)});

    always_comb begin
        idx_d = idx_q;
        if (start) begin
            idx_d = 4'd1;
        end else if (check) begin
            if (match_done)   idx_d = 4'd0;
            else if (match)   idx_d = idx_q + 4'd1;
            else if (restart) idx_d = 4'd1;
            else              idx_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= 4'd0;
        else        idx_q <= idx_d;
    end

endmodule

// File: rtl/depacketizer.sv
// Framed byte stream decoder: recovers pixel lines and control packets.
// Optional control length check enabled by DEPKT_CTRL_LEN_CHECK_EN (adds ctrl_len_err).
module depacketizer
    import depkt_pkg::*;
#(
    parameter int unsigned LINE_W   = 11,
    parameter int unsigned CTRL_LEN = 110,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        in_data,
    input  logic              in_valid,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic              line_start,
    output logic              line_end,
    output logic [LINE_W-1:0] line_len,
    output logic              frame_start,
    output logic [7:0]        ctrl_data,
    output logic              ctrl_valid,
    output logic              ctrl_done,
    output logic [ERR_W-1:0]  sync_err_cnt,
    output logic [ERR_W-1:0]  ovf_err_cnt,
    output logic              busy
`ifdef DEPKT_CTRL_LEN_CHECK_EN
    ,
    output logic              ctrl_len_err
`endif
);

    localparam logic [LINE_W-1:0] PIX_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [LINE_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [6:0]        ctrl_cnt_q, ctrl_cnt_d;
    logic [7:0]        pix_data_d, ctrl_data_d;
    logic [LINE_W-1:0] line_len_d;
    logic              pix_valid_d, line_start_d, line_end_d;
    logic              frame_start_d, ctrl_valid_d, ctrl_done_d;
    logic              sync_inc, ovf_inc;
    logic [ERR_W-1:0]  sync_err_d, ovf_err_d;
    logic              hunt_hit, hdr_check;
    logic              match_done, mismatch, restart;
`ifdef DEPKT_CTRL_LEN_CHECK_EN
    logic              len_err_d;
`endif

    assign hunt_hit  = in_valid && (state_q == ST_HUNT) &&
                       (in_data == {1'b1, sync_byte(4'd0)});
    assign hdr_check = in_valid && (state_q == ST_HEADER);

    depkt_sync_match u_sync_match (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (hunt_hit),
        .check      (hdr_check),
        .in_data    (in_data),
        .match_done (match_done),
        .mismatch   (mismatch),
        .restart    (restart)
    );

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        ctrl_cnt_d    = ctrl_cnt_q;
        pix_data_d    = pix_data;
        ctrl_data_d   = ctrl_data;
        line_len_d    = line_len;
        pix_valid_d   = 1'b0;
        line_start_d  = 1'b0;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;
        ctrl_valid_d  = 1'b0;
        ctrl_done_d   = 1'b0;
        sync_inc      = 1'b0;
        ovf_inc       = 1'b0;
`ifdef DEPKT_CTRL_LEN_CHECK_EN
        len_err_d     = 1'b0;
`endif
        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (hunt_hit) state_d = ST_HEADER;
                end
                ST_HEADER: begin
                    if (match_done) begin
                        state_d = ST_TYPE;
                    end else if (mismatch) begin
                        sync_inc = 1'b1;
                        if (!restart) state_d = ST_HUNT;
                    end
                end
                ST_TYPE: begin
                    if (in_data == {1'b1, TYPE_DATA}) begin
                        state_d   = ST_DATA;
                        pix_cnt_d = '0;
                    end else if (in_data == {1'b1, TYPE_CTRL}) begin
                        state_d       = ST_CTRL;
                        frame_start_d = 1'b1;
                        ctrl_cnt_d    = '0;
                    end else begin
                        state_d  = ST_HUNT;
                        sync_inc = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (!in_data[8]) begin
                        line_end_d = 1'b1;
                        line_len_d = pix_cnt_q;
                        state_d    = ST_HUNT;
                    end else if (pix_cnt_q == PIX_MAX) begin
                        ovf_inc = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        pix_valid_d  = 1'b1;
                        pix_data_d   = in_data[7:0];
                        line_start_d = (pix_cnt_q == '0);
                        pix_cnt_d    = pix_cnt_q + 1'b1;
                    end
                end
                ST_CTRL: begin
                    if (!in_data[8]) begin
                        ctrl_done_d = 1'b1;
                        state_d     = ST_HUNT;
`ifdef DEPKT_CTRL_LEN_CHECK_EN
                        if (32'(ctrl_cnt_q) != CTRL_LEN) begin
                            len_err_d = 1'b1;
                            ovf_inc   = 1'b1;
                        end
`endif
                    end else if (ctrl_cnt_q == CTRL_MAX) begin
                        ovf_inc = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        ctrl_valid_d = 1'b1;
                        ctrl_data_d  = in_data[7:0];
                        ctrl_cnt_d   = ctrl_cnt_q + 7'd1;
                    end
                end
                ST_DROP: begin
                    if (!in_data[8]) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Error counters stick at all-ones.
    always_comb begin
        sync_err_d = sync_err_cnt;
        ovf_err_d  = ovf_err_cnt;
        if (sync_inc && (sync_err_cnt != '1)) sync_err_d = sync_err_cnt + ERR_W'(1);
        if (ovf_inc && (ovf_err_cnt != '1))   ovf_err_d  = ovf_err_cnt + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            pix_cnt_q    <= '0;
            ctrl_cnt_q   <= '0;
            pix_data     <= '0;
            pix_valid    <= 1'b0;
            line_start   <= 1'b0;
            line_end     <= 1'b0;
            line_len     <= '0;
            frame_start  <= 1'b0;
            ctrl_data    <= '0;
            ctrl_valid   <= 1'b0;
            ctrl_done    <= 1'b0;
            sync_err_cnt <= '0;
            ovf_err_cnt  <= '0;
            busy         <= 1'b0;
`ifdef DEPKT_CTRL_LEN_CHECK_EN
            ctrl_len_err <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            ctrl_cnt_q   <= ctrl_cnt_d;
            pix_data     <= pix_data_d;
            pix_valid    <= pix_valid_d;
            line_start   <= line_start_d;
            line_end     <= line_end_d;
            line_len     <= line_len_d;
            frame_start  <= frame_start_d;
            ctrl_data    <= ctrl_data_d;
            ctrl_valid   <= ctrl_valid_d;
            ctrl_done    <= ctrl_done_d;
            sync_err_cnt <= sync_err_d;
            ovf_err_cnt  <= ovf_err_d;
            busy         <= (state_d != ST_HUNT);
`ifdef DEPKT_CTRL_LEN_CHECK_EN
            ctrl_len_err <= len_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_depacketizer.sv
// Scoreboard bench for depacketizer: stream-level reference parser feeds an expected-event queue.
module tb_depacketizer;

    localparam int unsigned LW      = 5;
    localparam int unsigned CL      = 110;
    localparam int unsigned EW      = 8;
    localparam int          PIX_LIM = (1 << LW) - 1;
    localparam int          CTL_LIM = 127;
    localparam int          ERR_SAT = (1 << EW) - 1;

    localparam int K_PIX = 0, K_LEND = 1, K_FST = 2, K_CTRL = 3, K_CDONE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    pix_data, ctrl_data;
    logic          pix_valid, line_start, line_end, frame_start, ctrl_valid, ctrl_done, busy;
    logic [LW-1:0] line_len;
    logic [EW-1:0] sync_err_cnt, ovf_err_cnt;
`ifdef DEPKT_CTRL_LEN_CHECK_EN
    logic          ctrl_len_err;
`endif

    depacketizer #(.LINE_W(LW), .CTRL_LEN(CL), .ERR_W(EW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .line_start   (line_start),
        .line_end     (line_end),
        .line_len     (line_len),
        .frame_start  (frame_start),
        .ctrl_data    (ctrl_data),
        .ctrl_valid   (ctrl_valid),
        .ctrl_done    (ctrl_done),
        .sync_err_cnt (sync_err_cnt),
        .ovf_err_cnt  (ovf_err_cnt),
        .busy         (busy)
`ifdef DEPKT_CTRL_LEN_CHECK_EN
        ,
        .ctrl_len_err (ctrl_len_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
        int flag;
    } ev_t;

    ev_t        exp_q[$];
    logic [8:0] stim[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_sync = 0;
    int         exp_ovf = 0;
    int         sync_tb [12] = '{'h0A, 'h01, 'h02, 'h03, 'h04, 'h05,
                                 'h0A, 'h01, 'h02, 'h03, 'h04, 'hCC};

    function automatic logic [8:0] hdr(input int k);
        return {1'b1, 8'(sync_tb[k])};
    endfunction

    function automatic void push_ev(input int k, input int v, input int f);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.flag = f;
        exp_q.push_back(e);
    endfunction

    function automatic void bump_sync();
        if (exp_sync < ERR_SAT) exp_sync++;
    endfunction

    function automatic void bump_ovf();
        if (exp_ovf < ERR_SAT) exp_ovf++;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: scan a whole byte stream the way a software decoder would.
    task automatic model_stream(input logic [8:0] s[$]);
        int  i, k, n;
        bit  ok, dead;
        logic [8:0] t;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != hdr(0)) begin
                i++;
                continue;
            end
            i++;
            k = 1; ok = 0; dead = 0;
            while (!ok && !dead && i < s.size()) begin
                if (s[i] == hdr(k)) begin
                    k++;
                    i++;
                    if (k == 12) ok = 1;
                end else begin
                    bump_sync();
                    if (s[i] == hdr(0)) k = 1;
                    else dead = 1;
                    i++;
                end
            end
            if (!ok || i >= s.size()) continue;
            t = s[i];
            i++;
            if (t == 9'h1FF || t == 9'h100) begin
                if (t == 9'h100) push_ev(K_FST, 0, 0);
                n = 0;
                while (i < s.size()) begin
                    if (!s[i][8]) begin
                        if (t == 9'h1FF) push_ev(K_LEND, n, 0);
                        else begin
`ifdef DEPKT_CTRL_LEN_CHECK_EN
                            push_ev(K_CDONE, 0, (n != CL) ? 1 : 0);
                            if (n != CL) bump_ovf();
`else
                            push_ev(K_CDONE, 0, 0);
`endif
                        end
                        i++;
                        break;
                    end
                    if (n == ((t == 9'h1FF) ? PIX_LIM : CTL_LIM)) begin
                        bump_ovf();
                        while (i < s.size() && s[i][8]) i++;
                        i++;
                        break;
                    end
                    if (t == 9'h1FF) push_ev(K_PIX, int'(s[i][7:0]), (n == 0) ? 1 : 0);
                    else push_ev(K_CTRL, int'(s[i][7:0]), 0);
                    n++;
                    i++;
                end
            end else begin
                bump_sync();
            end
        end
    endtask

    // Monitor: every output strobe must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                int  ns;
                ev_t a, e;
                ns = int'(pix_valid) + int'(line_end) + int'(frame_start) +
                     int'(ctrl_valid) + int'(ctrl_done);
                if (ns > 0) begin
                    a.val = 0; a.flag = 0;
                    if (pix_valid) begin
                        a.kind = K_PIX; a.val = int'(pix_data); a.flag = int'(line_start);
                    end else if (line_end) begin
                        a.kind = K_LEND; a.val = int'(line_len);
                    end else if (frame_start) begin
                        a.kind = K_FST;
                    end else if (ctrl_valid) begin
                        a.kind = K_CTRL; a.val = int'(ctrl_data);
                    end else begin
                        a.kind = K_CDONE;
`ifdef DEPKT_CTRL_LEN_CHECK_EN
                        a.flag = int'(ctrl_len_err);
`endif
                    end
                    if (ns > 1) check("one_strobe_per_cycle", ns, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_strobe: got kind %0d val %0d, expected none",
                                 a.kind, a.val);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", a.kind, e.kind);
                        check("event_value", a.val, e.val);
                        check("event_flag", a.flag, e.flag);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [8:0] b, input int maxgap);
        int g;
        g = $urandom_range(maxgap, 0);
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 9'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic add_sync();
        for (int k = 0; k < 12; k++) stim.push_back(hdr(k));
    endtask

    task automatic add_packet(input logic [7:0] typ, input int len, input logic [7:0] fill,
                              input bit rnd);
        add_sync();
        stim.push_back({1'b1, typ});
        for (int k = 0; k < len; k++) stim.push_back({1'b1, rnd ? 8'($urandom) : fill});
        stim.push_back(9'h000);
    endtask

    task automatic run_stream(input int maxgap);
        int t;
        stim.push_back(9'h000);
        model_stream(stim);
        foreach (stim[k]) send_byte(stim[k], maxgap);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_pending_events", exp_q.size(), 0);
            exp_q.delete();
        end
        check("sync_err_cnt", int'(sync_err_cnt), exp_sync);
        check("ovf_err_cnt", int'(ovf_err_cnt), exp_ovf);
        check("busy_idle", int'(busy), 0);
        stim.delete();
    endtask

    initial begin
        int r;
        repeat (3) @(negedge clk);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_line_len", int'(line_len), 0);
        check("init_sync_err", int'(sync_err_cnt), 0);
        check("init_ovf_err", int'(ovf_err_cnt), 0);
        check("init_ctrl_valid", int'(ctrl_valid), 0);

        // Clean data packet 10..1F.
        add_sync();
        stim.push_back(9'h1FF);
        for (int k = 'h10; k <= 'h1F; k++) stim.push_back({1'b1, 8'(k)});
        stim.push_back(9'h000);
        run_stream(0);
        check("clean_line_len", int'(line_len), 16);
        check("clean_sync_err", int'(sync_err_cnt), 0);

        // Control packets of correct and short length.
        add_packet(8'h00, 110, 8'hA5, 0);
        run_stream(1);
        add_packet(8'h00, 109, 8'hA5, 0);
        run_stream(1);

        // Corrupted header resynchronising on the second 0A.
        foreach (sync_tb[k]) if (k < 3) stim.push_back(hdr(k));
        add_sync();
        stim.push_back(9'h1FF);
        stim.push_back(9'h155);
        stim.push_back(9'h000);
        run_stream(2);
        check("resync_sync_err", int'(sync_err_cnt), 1);

        // Bad type byte.
        add_sync();
        stim.push_back(9'h17E);
        run_stream(1);
        check("bad_type_sync_err", int'(sync_err_cnt), 2);

        // Overrun, then an empty line and a normal line.
        add_packet(8'hFF, 40, 8'h00, 1);
        run_stream(1);
        check("overrun_ovf_err", int'(ovf_err_cnt), 1);
        add_packet(8'hFF, 0, 8'h00, 0);
        add_packet(8'hFF, 5, 8'h00, 1);
        run_stream(1);

        // Randomised packet mix.
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(5, 0);
            case (r)
                0, 1: add_packet(8'hFF, $urandom_range(40, 0), 8'h00, 1);
                2: add_packet(8'h00, ($urandom_range(2, 0) == 0) ? 110 :
                              $urandom_range(130, 100), 8'h00, 1);
                3: begin
                    int pos;
                    pos = $urandom_range(11, 1);
                    for (int k = 0; k < 12; k++)
                        stim.push_back((k == pos) ? 9'($urandom) : hdr(k));
                    stim.push_back(9'h1FF);
                    for (int k = 0; k < 3; k++) stim.push_back({1'b1, 8'($urandom)});
                    stim.push_back(9'h000);
                end
                4: begin
                    add_sync();
                    stim.push_back({1'b1, 8'($urandom_range(254, 1))});
                end
                default: begin
                    for (int k = 0; k < 4; k++) stim.push_back(9'($urandom));
                    stim.push_back(9'h000);
                end
            endcase
            if (p % 8 == 7) run_stream(2);
        end
        run_stream(2);

        // Saturate the sync error counter.
        for (int p = 0; p < 260; p++) begin
            add_sync();
            stim.push_back(9'h17E);
        end
        run_stream(0);
        check("sync_err_saturated", int'(sync_err_cnt), 255);

        // Reset mid-DATA with input gaps.
        add_sync();
        stim.push_back(9'h1FF);
        for (int k = 0; k < 6; k++) stim.push_back({1'b1, 8'(8'h60 + k)});
        model_stream(stim);
        foreach (stim[k]) send_byte(stim[k], 2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pix_before_reset", int'(pix_valid), 1);
        rst_n = 1'b0;
        #1;
        check("reset_pix_valid", int'(pix_valid), 0);
        check("reset_pix_data", int'(pix_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_sync_err", int'(sync_err_cnt), 0);
        exp_q.delete();
        stim.delete();
        exp_sync = 0;
        exp_ovf  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add_packet(8'hFF, 7, 8'h00, 1);
        run_stream(1);
        check("post_reset_line_len", int'(line_len), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
